// File: rtl/store_drain_unit.sv
// Store buffer drain consumer: tag lookup, byte-masked hit write, write-allocate line fill on miss.
// Optional STORE_DRAIN_NO_ALLOCATE_EN turns the miss path into a write-around memory store.

module store_drain_lane #(
    parameter int LANE  = 0,
    parameter int OFF_W = 4
) (
    input  logic [OFF_W-1:0] off,
    input  logic             is_byte,
    input  logic [31:0]      data,
    input  logic [7:0]       fill_byte,
    output logic [7:0]       st_byte,
    output logic             st_mask,
    output logic [7:0]       merged
);
    localparam logic [OFF_W-1:0] LANE_IDX = OFF_W'(LANE);

    always_comb begin
        st_mask = 1'b0;
        st_byte = 8'h00;
        if (is_byte) begin
            st_mask = (off == LANE_IDX);
            if (st_mask) st_byte = data[7:0];
        end else begin
            // Word stores ignore off[1:0]: the lane belongs if it sits in the same aligned word.
            st_mask = ((off >> 2) == (LANE_IDX >> 2));
            if (st_mask) st_byte = data[8*(LANE%4) +: 8];
        end
        merged = st_mask ? st_byte : fill_byte;
    end
endmodule

module store_drain_unit #(
    parameter int LINE_BYTES = 16,
    parameter int ADDR_W     = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    drain_in,
    input  logic [ADDR_W-1:0]       addr_in,
    input  logic [31:0]             data_in,
    input  logic                    is_byte_in,
    output logic                    stall_out,
    output logic [ADDR_W-1:0]       tag_addr,
    input  logic                    tag_hit,
    output logic                    cache_we,
    output logic                    cache_fill,
    output logic [ADDR_W-1:0]       cache_addr,
    output logic [8*LINE_BYTES-1:0] cache_wdata,
    output logic [LINE_BYTES-1:0]   cache_wmask,
    output logic                    mem_req,
    output logic [ADDR_W-1:0]       mem_addr,
    input  logic                    mem_ready,
    input  logic [8*LINE_BYTES-1:0] mem_rdata
`ifdef STORE_DRAIN_NO_ALLOCATE_EN
    ,
    output logic                    mem_we,
    output logic [LINE_BYTES-1:0]   mem_wmask,
    output logic [8*LINE_BYTES-1:0] mem_wdata
`endif
);
    localparam int OFF_W = $clog2(LINE_BYTES);

    typedef enum logic [1:0] {IDLE, LOOKUP, MEM, WRITE} state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
        logic              is_byte;
    } store_t;

    state_t state;
    store_t cap;

    logic [ADDR_W-1:0]                line_addr;
    logic [LINE_BYTES-1:0][7:0]       st_bytes;
    logic [LINE_BYTES-1:0][7:0]       merged;
    logic [LINE_BYTES-1:0]            st_mask;

    assign line_addr = {cap.addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

    for (genvar i = 0; i < LINE_BYTES; i++) begin : g_lane
        store_drain_lane #(.LANE(i), .OFF_W(OFF_W)) u_lane (
            .off       (cap.addr[OFF_W-1:0]),
            .is_byte   (cap.is_byte),
            .data      (cap.data),
            .fill_byte (mem_rdata[8*i +: 8]),
            .st_byte   (st_bytes[i]),
            .st_mask   (st_mask[i]),
            .merged    (merged[i])
        );
    end

`ifdef STORE_DRAIN_NO_ALLOCATE_EN
    logic unused_merged;
    assign unused_merged = ^merged;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cap         <= '0;
            stall_out   <= 1'b0;
            tag_addr    <= '0;
            cache_we    <= 1'b0;
            cache_fill  <= 1'b0;
            cache_addr  <= '0;
            cache_wdata <= '0;
            cache_wmask <= '0;
            mem_req     <= 1'b0;
            mem_addr    <= '0;
`ifdef STORE_DRAIN_NO_ALLOCATE_EN
            mem_we      <= 1'b0;
            mem_wmask   <= '0;
            mem_wdata   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (drain_in) begin
                        cap       <= '{addr: addr_in, data: data_in, is_byte: is_byte_in};
                        tag_addr  <= {addr_in[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        stall_out <= 1'b1;
                        state     <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (tag_hit) begin
                        cache_we    <= 1'b1;
                        cache_fill  <= 1'b0;
                        cache_addr  <= line_addr;
                        cache_wdata <= st_bytes;
                        cache_wmask <= st_mask;
                        state       <= WRITE;
                    end else begin
                        mem_req  <= 1'b1;
                        mem_addr <= line_addr;
`ifdef STORE_DRAIN_NO_ALLOCATE_EN
                        mem_we    <= 1'b1;
                        mem_wmask <= st_mask;
                        mem_wdata <= st_bytes;
`endif
                        state    <= MEM;
                    end
                end
                MEM: begin
                    if (mem_ready) begin
                        mem_req <= 1'b0;
`ifdef STORE_DRAIN_NO_ALLOCATE_EN
                        mem_we    <= 1'b0;
                        stall_out <= 1'b0;
                        state     <= IDLE;
`else
                        // Store lanes override the fetched line before allocation.
                        cache_we    <= 1'b1;
                        cache_fill  <= 1'b1;
                        cache_addr  <= line_addr;
                        cache_wdata <= merged;
                        cache_wmask <= '1;
                        state       <= WRITE;
`endif
                    end
                end
                WRITE: begin
                    cache_we   <= 1'b0;
                    cache_fill <= 1'b0;
                    stall_out  <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_store_drain_unit.sv
// Directed bench for store_drain_unit: hit/miss placement, latency, held-store handshake, reset.
module tb_store_drain_unit;
    logic         clk = 1'b0;
    logic         reset;
    logic         drain_in;
    logic [31:0]  addr_in;
    logic [31:0]  data_in;
    logic         is_byte_in;
    logic         stall_out;
    logic [31:0]  tag_addr;
    logic         tag_hit;
    logic         cache_we;
    logic         cache_fill;
    logic [31:0]  cache_addr;
    logic [127:0] cache_wdata;
    logic [15:0]  cache_wmask;
    logic         mem_req;
    logic [31:0]  mem_addr;
    logic         mem_ready;
    logic [127:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    store_drain_unit #(.LINE_BYTES(16), .ADDR_W(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .drain_in    (drain_in),
        .addr_in     (addr_in),
        .data_in     (data_in),
        .is_byte_in  (is_byte_in),
        .stall_out   (stall_out),
        .tag_addr    (tag_addr),
        .tag_hit     (tag_hit),
        .cache_we    (cache_we),
        .cache_fill  (cache_fill),
        .cache_addr  (cache_addr),
        .cache_wdata (cache_wdata),
        .cache_wmask (cache_wmask),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ready   (mem_ready),
        .mem_rdata   (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic present(input logic [31:0] a, input logic [31:0] d, input logic b);
        drain_in   = 1'b1;
        addr_in    = a;
        data_in    = d;
        is_byte_in = b;
    endtask

    function automatic logic [127:0] outs_ctl();
        return {12'h0, stall_out, cache_we, cache_fill, mem_req,
                tag_addr, cache_addr, mem_addr, cache_wmask};
    endfunction

    initial begin
        logic [6:0] we_seq, st_seq;
        int wr_cnt;
        reset = 1'b0; drain_in = 1'b0; addr_in = '0; data_in = '0; is_byte_in = 1'b0;
        tag_hit = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
        step(); step();
        chk("reset_ctl", outs_ctl(), 128'h0);
        chk("reset_wdata", cache_wdata, 128'h0);
        reset = 1'b1;
        step();

        // Byte hit
        present(32'h1000_0005, 32'h0000_00AB, 1'b1); tag_hit = 1'b1;
        step(); drain_in = 1'b0;
        chk("bh_stall_e1", stall_out, 1);
        chk("bh_we_e1", cache_we, 0);
        chk("bh_tag_addr", tag_addr, 32'h1000_0000);
        step();
        chk("bh_we_e2", cache_we, 1);
        chk("bh_stall_e2", stall_out, 1);
        chk("bh_fill", cache_fill, 0);
        chk("bh_addr", cache_addr, 32'h1000_0000);
        chk("bh_mask", cache_wmask, 16'h0020);
        chk("bh_wdata", cache_wdata, 128'h0000_0000_0000_0000_0000_AB00_0000_0000);
        step();
        chk("bh_stall_e3", stall_out, 0);
        chk("bh_we_e3", cache_we, 0);

        // Word hit with misaligned low bits
        present(32'h2000_000E, 32'hDEAD_BEEF, 1'b0);
        step(); drain_in = 1'b0;
        step();
        chk("wh_we", cache_we, 1);
        chk("wh_addr", cache_addr, 32'h2000_0000);
        chk("wh_mask", cache_wmask, 16'hF000);
        chk("wh_wdata", cache_wdata, 128'hDEADBEEF_00000000_00000000_00000000);
        step();

        // Word miss, write-allocate
        present(32'h3000_0004, 32'h1122_3344, 1'b0); tag_hit = 1'b0;
        step(); drain_in = 1'b0;
        chk("wm_stall_lookup", stall_out, 1);
        wr_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("wm_mem_req", mem_req, 1);
            chk("wm_mem_addr", mem_addr, 32'h3000_0000);
            if (cache_we) wr_cnt++;
        end
        mem_ready = 1'b1; mem_rdata = {128{1'b1}};
        step();
        mem_ready = 1'b0; mem_rdata = '0;
        chk("wm_we", cache_we, 1);
        chk("wm_fill", cache_fill, 1);
        chk("wm_mask", cache_wmask, 16'hFFFF);
        chk("wm_wdata", cache_wdata, 128'hFFFFFFFF_FFFFFFFF_11223344_FFFFFFFF);
        chk("wm_req_done", mem_req, 0);
        step();
        if (cache_we) wr_cnt++;
        chk("wm_no_dup_write", wr_cnt, 0);
        chk("wm_idle", stall_out, 0);
        step();

        // Held-store handshake: drain held while stalled, dropped when stall falls
        present(32'h4000_0003, 32'h0000_0077, 1'b1); tag_hit = 1'b1;
        wr_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (cache_we) wr_cnt++;
            if (!stall_out) drain_in = 1'b0;
        end
        chk("held_write_count", wr_cnt, 1);

        // Back-to-back hits
        present(32'h4000_0001, 32'h0000_0055, 1'b1);
        we_seq = '0; st_seq = '0;
        for (int s = 1; s <= 7; s++) begin
            step();
            we_seq[s-1] = cache_we;
            st_seq[s-1] = stall_out;
            if (s == 2) begin
                chk("b2b_a_mask", cache_wmask, 16'h0002);
                chk("b2b_a_wdata", cache_wdata, 128'h5500);
            end
            if (s == 5) begin
                chk("b2b_b_mask", cache_wmask, 16'h0F00);
                chk("b2b_b_wdata", cache_wdata, 128'h00000000_CAFEF00D_00000000_00000000);
            end
            if (s == 3) present(32'h4000_0008, 32'hCAFE_F00D, 1'b0);
            if (s == 6) drain_in = 1'b0;
        end
        chk("b2b_we_seq", we_seq, 7'b0010010);
        chk("b2b_stall_seq", st_seq, 7'b0011011);

        // Reset during MEM
        present(32'h5000_0008, 32'h0102_0304, 1'b0); tag_hit = 1'b0;
        step(); drain_in = 1'b0;
        step();
        chk("rst_mem_req_before", mem_req, 1);
        #2 reset = 1'b0;
        #1;
        chk("rst_mem_req_async", mem_req, 0);
        chk("rst_stall_async", stall_out, 0);
        @(negedge clk); reset = 1'b1;
        step(); step();
        chk("rst_after_ctl", outs_ctl(), 128'h0);
        chk("rst_after_wdata", cache_wdata, 128'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
